uart_word_tx: RTL

- Transmit-side counterpart of the byte-to-word assembler (uart_sr).
- Accepts `WORD_WIDTH` words into a small FIFO and splits each word into bytes, most-significant byte first.
- Feeds the bytes one at a time to uart_tx through uart_tx's start_n / data / ready_to_send handshake.
- Sits between the CPU/host-side word producer and uart_tx. Words sent through uart_tx → uart_rx → uart_sr arrive unchanged.

---
 rtl/uart_word_tx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_word_tx.sv
// uart_word_tx
// ------------
// Transmit-side word splitter for uart_tx. Words from the host are queued in
// a small FIFO. Each word is then cut into bytes, most-significant byte
// first, and handed to uart_tx one byte at a time through its
// start_n / data / ready_to_send handshake. A uart_rx + uart_sr pair on the
// far end reassembles the same words.
//
// Parameters
//   WORD_WIDTH  word width in bits; must be a multiple of 8
//   DEPTH       FIFO depth in words; must be a power of 2 and at least 2
//
// Ports
//   clk               system clock, all logic on the rising edge
//   rst               synchronous reset, active-high
//   word_valid        producer presents a word on `word`
//   word              word to transmit
//   word_ready        FIFO has room; accept happens when word_valid && word_ready
//   tx_ready_to_send  uart_tx idle indication (high = idle)
//   tx_start_n        active-low start request to uart_tx
//   tx_data           byte currently offered to uart_tx
//   busy              FIFO non-empty or a word still being sent

module uart_word_tx #(
    parameter int WORD_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  word_valid,
    input  logic [WORD_WIDTH-1:0] word,
    output logic                  word_ready,
    input  logic                  tx_ready_to_send,
    output logic                  tx_start_n,
    output logic [7:0]            tx_data,
    output logic                  busy
);

    localparam int BYTES = WORD_WIDTH / 8;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_t;

    state_t                state_q;
    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [WORD_WIDTH-1:0] sr_q;
    logic [WORD_WIDTH-1:0] sr_shifted;
    logic [IDX_W-1:0]      byte_idx_q;
    logic                  tx_start_n_q;
    logic [7:0]            tx_data_q;
    logic                  push;
    logic                  pop;

    assign word_ready = (count_q != CNT_W'(DEPTH));
    assign push       = word_valid && word_ready;
    // A word leaves the FIFO only when the FSM is idle and uart_tx can take a byte.
    assign pop        = (state_q == IDLE) && (count_q != '0) && tx_ready_to_send;
    assign sr_shifted = sr_q << 8;

    assign tx_start_n = tx_start_n_q;
    assign tx_data    = tx_data_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);

    // FIFO bookkeeping. Pointers are exactly log2(DEPTH) bits wide, so they
    // wrap on their own. A simultaneous push and pop leaves the count alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage. It has no reset because the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

    // Byte sequencer. START holds the request until uart_tx shows it has
    // taken the byte by dropping ready_to_send. WAIT then waits for uart_tx
    // to become idle again before offering the next byte. tx_data is only
    // loaded together with the falling edge of tx_start_n, so it stays
    // stable for the whole time the request is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            sr_q         <= '0;
            byte_idx_q   <= '0;
            tx_start_n_q <= 1'b1;
            tx_data_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        sr_q         <= mem_q[rd_ptr_q];
                        byte_idx_q   <= '0;
                        tx_data_q    <= mem_q[rd_ptr_q][WORD_WIDTH-1 -: 8];
                        tx_start_n_q <= 1'b0;
                        state_q      <= START;
                    end
                end
                START: begin
                    if (!tx_ready_to_send) begin
                        tx_start_n_q <= 1'b1;
                        state_q      <= WAIT;
                    end
                end
                WAIT: begin
                    if (tx_ready_to_send) begin
                        if (byte_idx_q == IDX_W'(BYTES - 1)) begin
                            state_q <= IDLE;
                        end else begin
                            byte_idx_q   <= byte_idx_q + IDX_W'(1);
                            sr_q         <= sr_shifted;
                            tx_data_q    <= sr_shifted[WORD_WIDTH-1 -: 8];
                            tx_start_n_q <= 1'b0;
                            state_q      <= START;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
